// File: rtl/unv_shift_seq_pkg.sv
// Shared constants, the state encoding and the op-to-mode decode for the unv_shift_seq
// command sequencer.
package unv_shift_pkg;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_SHR  = 2'b01;
  localparam logic [1:0] M_SHL  = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Rotate right is a right shift whose serial input is fed back from the LSB.
  function automatic logic [1:0] shift_mode(input logic [1:0] op);
    logic [1:0] mode;
    case (op)
      OP_SHR:  mode = M_SHR;
      OP_ROT:  mode = M_SHR;
      OP_SHL:  mode = M_SHL;
      default: mode = M_HOLD;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/unv_shift_seq_if.sv
// Command and shift-register control bundle between a command source, the sequencer
// and the driven shift register. The sequencer uses the slave modport.
interface unv_shift_seq_if #(
  parameter int W  = 4,
  parameter int CW = 3
);
  logic          in_cmd_valid;
  logic          o_cmd_ready;
  logic [1:0]    in_cmd_op;
  logic [CW-1:0] in_cmd_cnt;
  logic [W-1:0]  in_cmd_data;
  logic          in_cmd_fill;
  logic [W-1:0]  in_q;
  logic [1:0]    o_m;
  logic [W-1:0]  o_l;
  logic          o_sir;
  logic          o_sil;
  logic          o_busy;
  logic          o_done;
  logic [W-1:0]  o_result;

  modport slave (
    input  in_cmd_valid, in_cmd_op, in_cmd_cnt, in_cmd_data, in_cmd_fill, in_q,
    output o_cmd_ready, o_m, o_l, o_sir, o_sil, o_busy, o_done, o_result
  );

  modport master (
    output in_cmd_valid, in_cmd_op, in_cmd_cnt, in_cmd_data, in_cmd_fill, in_q,
    input  o_cmd_ready, o_m, o_l, o_sir, o_sil, o_busy, o_done, o_result
  );
endinterface

// File: rtl/unv_shift_seq_cnt.sv
// Loadable down-counter holding the remaining shift steps; is_one marks the final
// shift cycle.
module unv_shift_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          is_one
);

  logic [CW-1:0] count_r;

  // Step counter: load wins over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign is_one = (count_r == CW'(1));

endmodule

// File: rtl/unv_shift_seq.sv
// Command sequencer driving a 4-bit universal shift register (load / shift / rotate).
// Define UNV_SHIFT_SEQ_ROTATE_EN to make op 11 a rotate right; otherwise op 11 is a no-op.
module unv_shift_seq #(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic            in_clk,
  input  logic            in_rst,
  unv_shift_seq_if.slave  bus
);
  import unv_shift_pkg::*;

`ifdef UNV_SHIFT_SEQ_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  state_t        state_r, state_next_s;
  logic [1:0]    op_r, op_next_s;
  logic [W-1:0]  data_r, data_next_s;
  logic          fill_r, fill_next_s;
  logic          accept_s, cnt_is_one_s, rot_sir_s;
  logic [1:0]    m_r, m_next_s;
  logic [W-1:0]  l_r, l_next_s, result_r;
  logic          sir_r, sir_next_s, sil_r, sil_next_s, busy_r, done_r;

  unv_shift_cnt #(.CW(CW)) u_cnt (
    .clk      (in_clk),
    .rst      (in_rst),
    .load     (accept_s),
    .dec      (state_r == SHIFT),
    .load_val (bus.in_cmd_cnt),
    .is_one   (cnt_is_one_s)
  );

  assign accept_s = bus.in_cmd_valid && (state_r == IDLE);

  // Next state plus the output decode of that next state, so outputs can be registered.
  always_comb begin
    state_next_s = state_r;
    op_next_s    = accept_s ? bus.in_cmd_op   : op_r;
    data_next_s  = accept_s ? bus.in_cmd_data : data_r;
    fill_next_s  = accept_s ? bus.in_cmd_fill : fill_r;
    m_next_s     = M_HOLD;
    l_next_s     = {W{1'b0}};
    sir_next_s   = 1'b0;
    sil_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_next_s = IDLE;
        end else if (bus.in_cmd_op == OP_LOAD) begin
          state_next_s = LOAD;
        end else if ((bus.in_cmd_op == OP_ROT) && !ROT_EN) begin
          state_next_s = DONE;
        end else if (bus.in_cmd_cnt == {CW{1'b0}}) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      LOAD:    state_next_s = DONE;
      SHIFT:   state_next_s = cnt_is_one_s ? DONE : SHIFT;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
    case (state_next_s)
      LOAD: begin
        m_next_s = M_LOAD;
        l_next_s = data_next_s;
      end
      SHIFT: begin
        m_next_s = shift_mode(op_next_s);
        if (op_next_s == OP_SHR) begin
          sir_next_s = fill_next_s;
        end else if (op_next_s == OP_SHL) begin
          sil_next_s = fill_next_s;
        end else begin
          sir_next_s = 1'b0;
        end
      end
      default: m_next_s = M_HOLD;
    endcase
  end

  // State, latched command and registered outputs; result captured while in DONE.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_r  <= IDLE;
      op_r     <= OP_LOAD;
      data_r   <= {W{1'b0}};
      fill_r   <= 1'b0;
      m_r      <= M_HOLD;
      l_r      <= {W{1'b0}};
      sir_r    <= 1'b0;
      sil_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {W{1'b0}};
    end else begin
      state_r  <= state_next_s;
      op_r     <= op_next_s;
      data_r   <= data_next_s;
      fill_r   <= fill_next_s;
      m_r      <= m_next_s;
      l_r      <= l_next_s;
      sir_r    <= sir_next_s;
      sil_r    <= sil_next_s;
      busy_r   <= (state_next_s != IDLE);
      done_r   <= (state_next_s == DONE);
      result_r <= (state_r == DONE) ? bus.in_q : result_r;
    end
  end

  // Rotate feeds the live LSB back into the MSB, so it cannot be registered.
  assign rot_sir_s = ROT_EN && (state_r == SHIFT) && (op_r == OP_ROT) && bus.in_q[0];

  assign bus.o_cmd_ready = (state_r == IDLE);
  assign bus.o_m         = m_r;
  assign bus.o_l         = l_r;
  assign bus.o_sir       = sir_r | rot_sir_s;
  assign bus.o_sil       = sil_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_done      = done_r;
  assign bus.o_result    = result_r;

endmodule

// File: tb/tb_unv_shift_seq.sv
// Directed bench: unv_shift_seq driving a behavioural 4-bit universal shift register.
module tb_unv_shift_seq;
  import unv_shift_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         reg_rst;
  logic [W-1:0] reg_q;

  int errors = 0;
  int checks = 0;
  int lat, n_shr, n_shl, n_load, n_done, n_sir;
  bit timeout;

  unv_shift_seq_if #(.W(W), .CW(CW)) bus ();

  unv_shift_seq #(.W(W), .CW(CW)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.in_q = reg_q;

  // Behavioural model of the driven shift register.
  always_ff @(posedge clk) begin
    if (reg_rst) begin
      reg_q <= 4'b0000;
    end else begin
      case (bus.o_m)
        M_SHR:   reg_q <= {bus.o_sir, reg_q[W-1:1]};
        M_SHL:   reg_q <= {reg_q[W-2:0], bus.o_sil};
        M_LOAD:  reg_q <= bus.o_l;
        default: reg_q <= reg_q;
      endcase
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [CW-1:0] cnt,
                       input logic [W-1:0] data, input logic fill, input bit hold_valid);
    bus.in_cmd_op    = op;
    bus.in_cmd_cnt   = cnt;
    bus.in_cmd_data  = data;
    bus.in_cmd_fill  = fill;
    bus.in_cmd_valid = 1'b1;
    step();
    if (!hold_valid) bus.in_cmd_valid = 1'b0;
  endtask

  // Runs from just after the accept edge until ready returns, tallying what was seen.
  task automatic collect;
    lat = 0; n_shr = 0; n_shl = 0; n_load = 0; n_done = 0; n_sir = 0; timeout = 1'b0;
    while (!bus.o_cmd_ready && !timeout) begin
      if (bus.o_m == M_SHR)  n_shr++;
      if (bus.o_m == M_SHL)  n_shl++;
      if (bus.o_m == M_LOAD) n_load++;
      if (bus.o_done)        n_done++;
      if (bus.o_sir)         n_sir++;
      step();
      lat++;
      if (lat > 50) timeout = 1'b1;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.o_m, bus.o_l, bus.o_sir, bus.o_sil, bus.o_busy, bus.o_done} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got m=%b l=%b sir=%b sil=%b busy=%b done=%b, expected all 0",
               bus.o_m, bus.o_l, bus.o_sir, bus.o_sil, bus.o_busy, bus.o_done);
    end
    checks++;
    if (bus.o_result !== 4'b0000 || bus.o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_result_ready: got result=%b ready=%b, expected 0000 and 1",
               bus.o_result, bus.o_cmd_ready);
    end
  endtask

  task automatic test_load;
    issue(OP_LOAD, 3'd0, 4'b0101, 1'b0, 1'b0);
    checks++;
    if (bus.o_m !== M_LOAD || bus.o_l !== 4'b0101 || bus.o_busy !== 1'b1 || bus.o_cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_cycle: got m=%b l=%b busy=%b ready=%b, expected 11 0101 1 0",
               bus.o_m, bus.o_l, bus.o_busy, bus.o_cmd_ready);
    end
    step();
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_m !== M_HOLD) begin
      errors++;
      $display("FAIL load_done: got done=%b m=%b, expected 1 00", bus.o_done, bus.o_m);
    end
    step();
    checks++;
    if (bus.o_cmd_ready !== 1'b1 || bus.o_done !== 1'b0 || bus.o_result !== 4'b0101) begin
      errors++;
      $display("FAIL load_result: got ready=%b done=%b result=%b, expected 1 0 0101",
               bus.o_cmd_ready, bus.o_done, bus.o_result);
    end
  endtask

  task automatic test_shift;
    issue(OP_SHR, 3'd1, 4'b0000, 1'b1, 1'b0);
    collect();
    checks++;
    if (timeout || n_shr != 1 || n_sir != 1 || n_done != 1 || lat != 2 || bus.o_result !== 4'b1010) begin
      errors++;
      $display("FAIL shr1: got to=%0d shr=%0d sir=%0d done=%0d lat=%0d result=%b, expected 0 1 1 1 2 1010",
               timeout, n_shr, n_sir, n_done, lat, bus.o_result);
    end
    issue(OP_SHL, 3'd2, 4'b0000, 1'b0, 1'b0);
    collect();
    checks++;
    if (timeout || n_shl != 2 || n_shr != 0 || n_done != 1 || lat != 3 || bus.o_result !== 4'b1000) begin
      errors++;
      $display("FAIL shl2: got to=%0d shl=%0d shr=%0d done=%0d lat=%0d result=%b, expected 0 2 0 1 3 1000",
               timeout, n_shl, n_shr, n_done, lat, bus.o_result);
    end
  endtask

  task automatic test_cnt_zero;
    issue(OP_SHR, 3'd0, 4'b0000, 1'b1, 1'b0);
    collect();
    checks++;
    if (timeout || (n_shr + n_shl + n_load) != 0 || n_sir != 0 || n_done != 1 || lat != 1
        || bus.o_result !== 4'b1000) begin
      errors++;
      $display("FAIL cnt_zero: got to=%0d moves=%0d sir=%0d done=%0d lat=%0d result=%b, expected 0 0 0 1 1 1000",
               timeout, n_shr + n_shl + n_load, n_sir, n_done, lat, bus.o_result);
    end
  endtask

  task automatic test_rotate;
    issue(OP_LOAD, 3'd0, 4'b0101, 1'b0, 1'b0);
    collect();
    checks++;
    if (timeout || bus.o_result !== 4'b0101) begin
      errors++;
      $display("FAIL rot_preload: got to=%0d result=%b, expected 0 0101", timeout, bus.o_result);
    end
    issue(OP_ROT, 3'd1, 4'b0000, 1'b0, 1'b0);
    collect();
`ifdef UNV_SHIFT_SEQ_ROTATE_EN
    checks++;
    if (timeout || n_shr != 1 || n_sir != 1 || n_done != 1 || lat != 2 || bus.o_result !== 4'b1010) begin
      errors++;
      $display("FAIL rot1: got to=%0d shr=%0d sir=%0d done=%0d lat=%0d result=%b, expected 0 1 1 1 2 1010",
               timeout, n_shr, n_sir, n_done, lat, bus.o_result);
    end
`else
    checks++;
    if (timeout || (n_shr + n_shl + n_load) != 0 || n_done != 1 || lat != 1 || bus.o_result !== 4'b0101) begin
      errors++;
      $display("FAIL rot_noop: got to=%0d moves=%0d done=%0d lat=%0d result=%b, expected 0 0 1 1 0101",
               timeout, n_shr + n_shl + n_load, n_done, lat, bus.o_result);
    end
`endif
  endtask

  task automatic test_back_to_back;
    issue(OP_LOAD, 3'd0, 4'b0001, 1'b0, 1'b0);
    collect();
    issue(OP_SHR, 3'd7, 4'b0000, 1'b0, 1'b1);
    bus.in_cmd_op  = OP_SHL;
    bus.in_cmd_cnt = 3'd3;
    collect();
    bus.in_cmd_valid = 1'b0;
    checks++;
    if (timeout || n_shr != 7 || n_shl != 0 || n_done != 1 || lat != 8 || bus.o_result !== 4'b0000) begin
      errors++;
      $display("FAIL busy_valid: got to=%0d shr=%0d shl=%0d done=%0d lat=%0d result=%b, expected 0 7 0 1 8 0000",
               timeout, n_shr, n_shl, n_done, lat, bus.o_result);
    end
    step();
    checks++;
    if (bus.o_cmd_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL no_queue: got ready=%b busy=%b, expected 1 0", bus.o_cmd_ready, bus.o_busy);
    end
  endtask

  task automatic test_reset_mid;
    int seen_done;
    issue(OP_LOAD, 3'd0, 4'b1111, 1'b0, 1'b0);
    collect();
    issue(OP_SHR, 3'd4, 4'b0000, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.o_m !== M_SHR || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_shift: got m=%b busy=%b, expected 01 1", bus.o_m, bus.o_busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.o_m !== M_HOLD || bus.o_busy !== 1'b0 || bus.o_cmd_ready !== 1'b1 || bus.o_done !== 1'b0
        || bus.o_result !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: got m=%b busy=%b ready=%b done=%b result=%b, expected 00 0 1 0 0000",
               bus.o_m, bus.o_busy, bus.o_cmd_ready, bus.o_done, bus.o_result);
    end
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_done) seen_done++;
      step();
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL mid_reset_done: got %0d done pulses, expected 0", seen_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    reg_rst = 1'b1;
    bus.in_cmd_valid = 1'b0;
    bus.in_cmd_op    = OP_LOAD;
    bus.in_cmd_cnt   = 3'd0;
    bus.in_cmd_data  = 4'b0000;
    bus.in_cmd_fill  = 1'b0;
    step();
    rst = 1'b0;
    reg_rst = 1'b0;
    test_reset();
    test_load();
    test_shift();
    test_cnt_zero();
    test_rotate();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
